// File: rtl/imem_fetch_unit_pkg.sv
// Shared definitions for the instruction-memory fetch unit.
//   DATA_W_DEF : default instruction word width in bits
//   ADDR_W_DEF : default word-address width of the PC
//   NOP        : all-zero instruction word. It is returned for bubbles, for
//                reset, and for fetches from unimplemented addresses.
package imem_fetch_unit_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 8;

    localparam logic [DATA_W_DEF-1:0] NOP = '0;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage with one synchronous read port and one write port.
// Ports:
//   clock          rising-edge clock
//   rd_en          capture mem[rd_addr] into rd_data at the edge
//   rd_clr         force rd_data to NOP at the edge (wins over rd_en)
//   rd_addr        read word address; addresses >= DEPTH read as NOP
//   rd_data        registered read word
//   wr_en          write strobe
//   wr_addr        write word address; addresses >= DEPTH are ignored
//   wr_data        word to write
// A read and a write to the same word on the same edge return the old word.
module imem_ram
    import imem_fetch_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP);

    // The declaration initialiser provides the all-zero power-up image.
    // Reset never touches the array.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic             rd_in_range;
    logic             wr_in_range;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    // The extra top bit keeps the compare exact when DEPTH == 2**ADDR_W.
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_idx      = rd_addr[IDX_W-1:0];
    assign wr_idx      = wr_addr[IDX_W-1:0];

    always_ff @(posedge clock) begin
        if (rd_clr) begin
            rd_data <= NOP_W;
        end else if (rd_en) begin
            rd_data <= rd_in_range ? mem[rd_idx] : NOP_W;
        end

        if (wr_en && wr_in_range) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// Sequential instruction fetch from a loadable on-chip instruction memory.
// Ports:
//   clock           rising-edge clock
//   reset           synchronous active-high reset. It wins over everything and
//                   also drops a program load in the same cycle.
//   stall           hold fetch state and outputs
//   redirect_valid  load fetch_pc from redirect_pc. This inserts one bubble
//                   and applies even while stalled.
//   redirect_pc     branch/jump target word address
//   load_en         program-load write strobe
//   load_addr       program-load word address (ignored when >= DEPTH)
//   load_data       program-load word
//   instruction     registered fetched word (NOP on bubble/reset/fault)
//   pc_out          word address of the current instruction
//   instr_valid     instruction/pc_out are meaningful
//   fetch_fault     pc_out lies outside the implemented DEPTH words
module imem_fetch_unit
    import imem_fetch_unit_pkg::*;
#(
    parameter int          DATA_W   = DATA_W_DEF,
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          DEPTH    = 2 ** ADDR_W_DEF,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    output logic              fetch_fault
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_oob;
    logic              rd_clr;
    logic              rd_en;
    logic              wr_en;

    assign fetch_oob = ({1'b0, fetch_pc} >= DEPTH_L);

    // The RAM output register is the instruction register. Reset and a
    // redirect both clear it, which produces the NOP bubble.
    assign rd_clr = reset | redirect_valid;
    assign rd_en  = ~stall;
    assign wr_en  = load_en & ~reset;

    imem_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clock   (clock),
        .rd_en   (rd_en),
        .rd_clr  (rd_clr),
        .rd_addr (fetch_pc),
        .rd_data (instruction),
        .wr_en   (wr_en),
        .wr_addr (load_addr),
        .wr_data (load_data)
    );

    // Fetch control: reset > redirect > stall > advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= ADDR_W'(RESET_PC);
            pc_out      <= '0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_pc;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (!stall) begin
            pc_out      <= fetch_pc;
            instr_valid <= 1'b1;
            fetch_fault <= fetch_oob;
            fetch_pc    <= fetch_pc + ADDR_W'(1);
        end
    end

endmodule
